gb_read_streamer: RTL and testbench
===================================

// Module: gb_read_streamer
// PURPOSE
// - Read-side stage directly downstream of the global buffer.
// - On a start command it issues a burst of interface-wide reads: len_i words from base_addr_i.
// - Returned words are captured in a small credit-managed FIFO.
// - Words are presented as a valid/ready stream with a last marker, feeding the PE-array multicast bus.
// PARAMETERS
// - dataSize       8     bits per element
// - interfaceDepth 16    elements per global-buffer word; word width W = dataSize*interfaceDepth
// - bufferDepth    1024  global buffer size in elements; AW = $clog2(bufferDepth)
// - gbLatency      1     cycles from gb_rd_en_o to gb_valid_i (fixed, >=1)
// - fifoDepth      4     output FIFO entries; must be >= gbLatency+2 (elaboration-time assert)
// - LW             16    width of len_i
// PORTS
// - clk          in   1    clock
// - rst          in   1    synchronous, active-high reset
// - start_i      in   1    start pulse; sampled only in IDLE
// - base_addr_i  in   AW   first element address; must be a multiple of interfaceDepth
// - len_i        in   LW   number of words to read
// - busy_o       out  1    high from the cycle after an accepted start until done_o
// - done_o       out  1    1-cycle pulse; burst complete
// - gb_addr_o    out  AW   read address to the global buffer
// - gb_rd_en_o   out  1    read strobe; one word per asserted cycle
// - gb_rd_data_i in   W    global buffer read data
// - gb_valid_i   in   1    read data valid
// - out_data_o   out  W    stream data
// - out_valid_o  out  1    stream valid
// - out_ready_i  in   1    stream ready from consumer
// - out_last_o   out  1    high with the final word of a burst
// BEHAVIOUR
// - One clock domain; reset is synchronous and active-high.
// - Reset: all outputs 0, FIFO empty, issued/outstanding/received counters 0, state IDLE.
// - FSM states: IDLE, ISSUE, DRAIN.
//   - IDLE -> ISSUE on start_i with len_i != 0; base and len are latched.
//   - start_i with len_i == 0: done_o pulses the next cycle, busy_o stays low, no reads.
//   - start_i while not IDLE is ignored.
//   - ISSUE -> DRAIN in the cycle the len-th read is issued.
//   - DRAIN -> IDLE when the last word is handshaken (out_valid_o & out_ready_i & out_last_o).
//     done_o pulses in the following cycle.
// - Read issue:
//   - gb_rd_en_o=1 in ISSUE only when credit > 0, where credit = fifoDepth - fifo_count - outstanding.
//   - Reads are registered outputs: first read is in the cycle after start.
//   - gb_addr_o advances by interfaceDepth per issued read and wraps modulo bufferDepth.
// - outstanding:
//   - +1 per issued read, -1 per gb_valid_i; both in one cycle leaves it unchanged.
//   - gb_valid_i with outstanding == 0 is dropped (e.g. returns after reset or from another master).
// - FIFO:
//   - Pushes on accepted gb_valid_i.
//   - Pops on out_valid_o & out_ready_i.
//   - Push and pop in the same cycle, including when full or empty-with-push, are both legal; count is unchanged.
//   - Never overflows, because credit accounts for in-flight reads.
//   - First-word-fall-through is not used: out_valid_o rises the cycle after the push.
// - out_last_o:
//   - Tagged at push time on the word whose received count == len.
//   - Held stable with out_data_o while out_valid_o & !out_ready_i (AXI-style stall; no data change while stalled).
// - Latency: start at cycle 0 -> gb_rd_en_o at cycle 1 -> out_valid_o at cycle 2+gbLatency.
// - Throughput: 1 word/cycle with out_ready_i held high.
// - Mid-burst reset: all state is discarded, no done_o, and in-flight returns are dropped.
// TESTING
// - T1: base=0, len=4, ready=1, gbLatency=1 -> reads at addr 0,16,32,48 in cycles 1-4.
//   out_valid_o cycles 3-6, last in cycle 6, done_o in cycle 7.
// - T2: len=0 -> no gb_rd_en_o, busy_o stays 0, done_o in cycle 1.
// - T3: len=10, out_ready_i=0 throughout.
//   -> exactly fifoDepth (4) reads issued, then gb_rd_en_o stays low; FIFO holds words 0-3 and out_data_o is stable.
//   Releasing ready -> all 10 words arrive in order, no loss, no duplication.
// - T4: base=bufferDepth-32, len=4 -> addresses 992,1008,0,16 (wrap).
// - T5: random out_ready_i, len=64 -> scoreboard matches GB content.
//   Assertions hold: fifo_count <= fifoDepth, last exactly once, done_o exactly once.
// - T6: rst asserted after 3 reads of len=8 -> all outputs 0 next cycle.
//   A late gb_valid_i is ignored; a new start with len=2 completes normally.

Source files
------------

// File: rtl/gb_read_streamer.sv
// Burst reader for the global buffer: issues len_i word reads from base_addr_i and
// streams the returned words out through a credit-managed FIFO with a last marker.
module gb_read_streamer #(
  parameter int DATA_SIZE       = 8,
  parameter int INTERFACE_DEPTH = 16,
  parameter int BUFFER_DEPTH    = 1024,
  parameter int GB_LATENCY      = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int LW              = 16,
  localparam int W  = DATA_SIZE * INTERFACE_DEPTH,
  localparam int AW = $clog2(BUFFER_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [LW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] gb_addr_o,
  output logic          gb_rd_en_o,
  input  logic [W-1:0]  gb_rd_data_i,
  input  logic          gb_valid_i,
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic [1:0]    dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < GB_LATENCY + 2) begin : g_depth_check
    $error("gb_read_streamer: FIFO_DEPTH must be at least GB_LATENCY+2");
  end

  // Stream handshake: a word transfers in a cycle where out_valid_o and out_ready_i
  // are both high; once out_valid_o is up, out_data_o/out_last_o hold until that transfer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issued_q, issued_d;
  logic [LW-1:0]   rcv_q, rcv_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    mem_data_q [FIFO_DEPTH];
  logic [W-1:0]    mem_data_d [FIFO_DEPTH];
  logic            mem_last_q [FIFO_DEPTH];
  logic            mem_last_d [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            push_last;
  logic            hs_last;
  logic [AW:0]     addr_sum;
  logic [AW-1:0]   addr_next;
  logic [CW:0]     used_slots;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign gb_addr_o   = addr_q;
  assign gb_rd_en_o  = rd_en_q;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_data_q[rd_ptr_q];
  assign out_last_o  = out_valid_o & mem_last_q[rd_ptr_q];
  assign dbg_state_o = state_q;

  // Returns with nothing in flight belong to no burst of ours and are discarded.
  assign push      = gb_valid_i && (outstanding_q != '0);
  assign pop       = out_valid_o && out_ready_i;
  assign push_last = ((rcv_q + LW'(1)) == len_q);
  assign hs_last   = pop && mem_last_q[rd_ptr_q];

  always_comb begin
    addr_sum = {1'b0, addr_q} + (AW + 1)'(INTERFACE_DEPTH);
    if (addr_sum >= (AW + 1)'(BUFFER_DEPTH)) begin
      addr_next = AW'(addr_sum - (AW + 1)'(BUFFER_DEPTH));
    end else begin
      addr_next = addr_sum[AW-1:0];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_en_q, push})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    used_slots = {1'b0, count_d} + {1'b0, outstanding_d};
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rcv_d      = rcv_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = gb_rd_data_i;
      mem_last_d[wr_ptr_q] = push_last;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
      rcv_d                = rcv_q + LW'(1);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            len_d    = len_i;
            addr_d   = base_addr_i;
            rd_en_d  = 1'b1;
            issued_d = LW'(1);
            rcv_d    = '0;
            busy_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // Credit is judged on next-cycle occupancy so every issued read has a slot waiting.
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (used_slots < (CW + 1)'(FIFO_DEPTH)) begin
          rd_en_d  = 1'b1;
          issued_d = issued_q + LW'(1);
          addr_d   = addr_next;
        end
      end
      S_DRAIN: begin
        if (hs_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      issued_q      <= '0;
      rcv_q         <= '0;
      addr_q        <= '0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      rcv_q         <= rcv_d;
      addr_q        <= addr_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= mem_data_d[i];
        mem_last_q[i] <= mem_last_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gb_read_streamer.sv
// Bench for gb_read_streamer: a one-cycle global-buffer responder, a negedge monitor
// with expected queues, a table of full-rate bursts, random bursts and corner sequences.
module tb_gb_read_streamer;

  localparam int W  = 128;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int NWORDS = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] gb_addr_o;
  logic          gb_rd_en_o;
  logic [W-1:0]  gb_rd_data_i = '0;
  logic          gb_valid_i = 1'b0;
  logic [W-1:0]  out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic          out_last_o;
  logic [1:0]    dbg_state_o;

  gb_read_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .gb_addr_o    (gb_addr_o),
    .gb_rd_en_o   (gb_rd_en_o),
    .gb_rd_data_i (gb_rd_data_i),
    .gb_valid_i   (gb_valid_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_last_o   (out_last_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- global buffer model ----------------
  logic [W-1:0] gb_mem [NWORDS];
  logic         stray_valid = 1'b0;

  always @(posedge clk) begin
    gb_valid_i   <= gb_rd_en_o | stray_valid;
    gb_rd_data_i <= gb_mem[gb_addr_o[AW-1:4]];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic          exp_last_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int reads_seen, hs_seen, lasts_seen, dones_seen, last_rd_addr;
  logic         stalled = 1'b0;
  logic [W-1:0] stall_data;
  logic         stall_last;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (gb_rd_en_o) begin
      reads_seen++;
      last_rd_addr = int'(gb_addr_o);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_read", W'(1), W'(0));
      end else begin
        check("read_addr", W'(gb_addr_o), W'(exp_addr_q.pop_front()));
      end
      check("in_flight_bound", W'((reads_seen - hs_seen) <= 4), W'(1));
    end
    if (stalled && out_valid_o) begin
      check("stall_data", out_data_o, stall_data);
      check("stall_last", W'(out_last_o), W'(stall_last));
    end
    stalled    = out_valid_o && !out_ready_i;
    stall_data = out_data_o;
    stall_last = out_last_o;
    if (out_valid_o && out_ready_i) begin
      hs_seen++;
      if (out_last_o) lasts_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", W'(1), W'(0));
      end else begin
        check("word_data", out_data_o, exp_q.pop_front());
        check("word_last", W'(out_last_o), W'(exp_last_q.pop_front()));
      end
    end
    if (done_o) dones_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic prep_burst(input int base, input int len);
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(AW'((base + 16 * i) % 1024));
      exp_q.push_back(gb_mem[((base / 16) + i) % NWORDS]);
      exp_last_q.push_back(i == len - 1);
    end
    reads_seen = 0;
    hs_seen    = 0;
    lasts_seen = 0;
    dones_seen = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int base, input int len, input int ready_pct,
                           input int stall_cyc, input bit full_rate, output int done_cyc);
    int  cyc;
    bit  seen_done;
    prep_burst(base, len);
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    len_i       = LW'(len);
    out_ready_i = (stall_cyc == 0) && ($urandom_range(99) < ready_pct);
    step();
    cyc       = 1;
    seen_done = 1'b0;
    done_cyc  = -1;
    while (!seen_done && cyc < 3000) begin
      out_ready_i = (cyc >= stall_cyc) && ($urandom_range(99) < ready_pct);
      if (cyc == 2) begin
        // a start while busy must be ignored
        start_i     = 1'b1;
        base_addr_i = AW'($urandom_range(63) * 16);
        len_i       = LW'($urandom_range(9));
      end else begin
        start_i = 1'b0;
      end
      if (cyc == 1) begin
        check("first_read_en", W'(gb_rd_en_o), W'(1));
        check("first_read_addr", W'(gb_addr_o), W'(base));
      end
      if (cyc == 2) check("no_valid_before_latency", W'(out_valid_o), W'(0));
      if (cyc == 3) check("first_valid", W'(out_valid_o), W'(1));
      if (full_rate) begin
        check("rd_en_timing", W'(gb_rd_en_o), W'(cyc <= len));
        check("valid_timing", W'(out_valid_o), W'(cyc >= 3 && cyc <= len + 2));
      end
      if (cyc == stall_cyc) begin
        check("stall_reads", W'(reads_seen), W'((len < 4) ? len : 4));
        check("stall_rd_en_low", W'(gb_rd_en_o), W'(0));
        check("stall_head", out_data_o, gb_mem[(base / 16) % NWORDS]);
      end
      if (done_o) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        check("busy_at_done", W'(busy_o), W'(0));
      end else begin
        check("busy_during", W'(busy_o), W'(1));
        step();
        cyc++;
      end
    end
    start_i = 1'b0;
    if (!seen_done) check("done_timeout", W'(0), W'(1));
    step();
    check("done_pulse_width", W'(done_o), W'(0));
    check("busy_after", W'(busy_o), W'(0));
    check("done_count", W'(dones_seen), W'(1));
    check("last_count", W'(lasts_seen), W'(1));
    check("read_count", W'(reads_seen), W'(len));
    check("word_count", W'(hs_seen), W'(len));
    check("exp_drained", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- test ----------------
  typedef struct {
    int base;
    int len;
    int exp_done;
    int exp_last_addr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dc;
    vecs[0] = '{base: 0,    len: 4,  exp_done: 7,  exp_last_addr: 48};
    vecs[1] = '{base: 992,  len: 4,  exp_done: 7,  exp_last_addr: 16};
    vecs[2] = '{base: 1008, len: 1,  exp_done: 4,  exp_last_addr: 1008};
    vecs[3] = '{base: 512,  len: 16, exp_done: 19, exp_last_addr: 752};
    vecs[4] = '{base: 960,  len: 8,  exp_done: 11, exp_last_addr: 48};
    vecs[5] = '{base: 16,   len: 3,  exp_done: 6,  exp_last_addr: 48};
    for (int i = 0; i < NWORDS; i++) gb_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    prep_burst(0, 0);

    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_done", W'(done_o), W'(0));
    check("rst_rd_en", W'(gb_rd_en_o), W'(0));
    check("rst_addr", W'(gb_addr_o), W'(0));
    check("rst_valid", W'(out_valid_o), W'(0));
    check("rst_data", out_data_o, W'(0));
    check("rst_last", W'(out_last_o), W'(0));
    rst = 1'b0;
    step();

    // full-rate table: T1, T4 wrap and friends
    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].base, vecs[v].len, 100, 0, 1'b1, dc);
      check("table_done_cycle", W'(dc), W'(vecs[v].exp_done));
      check("table_last_addr", W'(last_rd_addr), W'(vecs[v].exp_last_addr));
      step();
    end

    // T2: zero-length start
    prep_burst(0, 0);
    start_i = 1'b1;
    len_i   = '0;
    step();
    start_i = 1'b0;
    check("len0_done", W'(done_o), W'(1));
    check("len0_busy", W'(busy_o), W'(0));
    check("len0_rd_en", W'(gb_rd_en_o), W'(0));
    step();
    check("len0_done_clear", W'(done_o), W'(0));
    check("len0_busy_after", W'(busy_o), W'(0));
    check("len0_reads", W'(reads_seen), W'(0));
    step();

    // T3: consumer stalled, credit limits issue, then release
    run_burst(0, 10, 100, 20, 1'b0, dc);
    step();

    // T5: long burst with random ready, then shorter random bursts
    run_burst(64 * ($urandom_range(15)), 64, 50, 0, 1'b0, dc);
    step();
    for (int r = 0; r < 6; r++) begin
      run_burst(16 * $urandom_range(63), $urandom_range(1, 40), $urandom_range(20, 100), 0, 1'b0, dc);
      repeat ($urandom_range(2)) step();
    end

    // T6: reset mid-burst, late and stray returns dropped, then a normal burst
    prep_burst(0, 8);
    start_i     = 1'b1;
    base_addr_i = '0;
    len_i       = LW'(8);
    out_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    step();
    check("pre_reset_reads", W'(reads_seen + int'(gb_rd_en_o)), W'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", W'(busy_o), W'(0));
    check("mid_rst_done", W'(done_o), W'(0));
    check("mid_rst_rd_en", W'(gb_rd_en_o), W'(0));
    check("mid_rst_addr", W'(gb_addr_o), W'(0));
    check("mid_rst_valid", W'(out_valid_o), W'(0));
    check("mid_rst_data", out_data_o, W'(0));
    check("mid_rst_last", W'(out_last_o), W'(0));
    prep_burst(0, 0);
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    check("late_return_dropped", W'(out_valid_o), W'(0));
    step();
    check("stray_return_dropped", W'(out_valid_o), W'(0));
    check("stray_no_busy", W'(busy_o), W'(0));
    step();
    run_burst(64, 2, 100, 0, 1'b1, dc);
    check("post_rst_done_cycle", W'(dc), W'(5));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
